// File: rtl/reg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard_pkg
//  Description : Shared processor constants for the register scoreboard:
//                architectural register count, in-flight counter width and
//                register-index width.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_scoreboard_pkg;
    localparam int SB_NREGS  = 16;  // architectural registers tracked
    localparam int SB_CNTW   = 2;   // per-register in-flight counter width
    localparam int REG_IDX_W = 4;   // register index width
endpackage
`default_nettype wire

// File: rtl/reg_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sb_counter
//  Description : Saturating in-flight write counter for one register.
//                Ports: clk, rst (async, active-high), inc (accepted issue),
//                dec (write-back retire), count (current value),
//                count_next (value after this edge), underflow (retire seen
//                while count is zero).
//  Revision    : 1.0  initial release
// ============================================================================
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNTW = SB_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            dec,
    output logic [CNTW-1:0] count,
    output logic [CNTW-1:0] count_next,
    output logic            underflow
);

    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CNTW-1:0] CNT_ZERO = '0;

    // Simultaneous issue and retire on this register cancel out, including
    // the zero-count case where the retire is also flagged as an underflow.
    always_comb begin
        underflow  = dec && (count == CNT_ZERO);
        count_next = count;
        if (inc && !dec) begin
            if (count != CNT_MAX) begin
                count_next = count + CNTW'(1);
            end
        end else if (dec && !inc && (count != CNT_ZERO)) begin
            count_next = count - CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= CNT_ZERO;
        end else begin
            count <= count_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Register scoreboard tracking issued-but-not-retired writes
//                per architectural register and raising a stall on RAW or
//                counter-saturation hazards.
//                Inputs : clk, rst, ISSUE_VALID, SRC1, SRC2, USE_SRC1,
//                         USE_SRC2, ISSUE_WB_EN, ISSUE_DEST, FLUSH, WB_EN,
//                         DEST_WB
//                Outputs: HAZARD (combinational), PENDING (registered),
//                         ERR (registered, sticky underflow)
//  Revision    : 1.0  initial release
// ============================================================================
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREGS = SB_NREGS,
    parameter int CNTW  = SB_CNTW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ISSUE_VALID,
    input  logic [REG_IDX_W-1:0] SRC1,
    input  logic [REG_IDX_W-1:0] SRC2,
    input  logic                 USE_SRC1,
    input  logic                 USE_SRC2,
    input  logic                 ISSUE_WB_EN,
    input  logic [REG_IDX_W-1:0] ISSUE_DEST,
    input  logic                 FLUSH,
    input  logic                 WB_EN,
    input  logic [REG_IDX_W-1:0] DEST_WB,
    output logic                 HAZARD,
    output logic [NREGS-1:0]     PENDING,
    output logic                 ERR
);

    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO = '0;

    logic [CNTW-1:0] counts     [NREGS];
    logic [CNTW-1:0] counts_nxt [NREGS];
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;
    logic [NREGS-1:0] underflow_vec;
    logic [NREGS-1:0] pending_nxt;

    logic src1_ready;
    logic src2_ready;
    logic dest_full;
    logic issue_accept;

    // A source whose only outstanding write retires this cycle is readable:
    // the register file writes on the falling edge, ahead of the ID read.
    function automatic logic src_ready(input logic [CNTW-1:0] cnt,
                                       input logic [REG_IDX_W-1:0] idx,
                                       input logic wb_en,
                                       input logic [REG_IDX_W-1:0] wb_idx);
        return (cnt == CNT_ZERO) ||
               ((cnt == CNT_ONE) && wb_en && (wb_idx == idx));
    endfunction

    always_comb begin
        src1_ready   = src_ready(counts[SRC1], SRC1, WB_EN, DEST_WB);
        src2_ready   = src_ready(counts[SRC2], SRC2, WB_EN, DEST_WB);
        // A full destination counter only frees up if it retires this cycle.
        dest_full    = ISSUE_WB_EN && (counts[ISSUE_DEST] == CNT_MAX) &&
                       !(WB_EN && (DEST_WB == ISSUE_DEST));
        HAZARD       = ISSUE_VALID && !FLUSH &&
                       ((USE_SRC1 && !src1_ready) ||
                        (USE_SRC2 && !src2_ready) ||
                        dest_full);
        issue_accept = ISSUE_VALID && ISSUE_WB_EN && !FLUSH && !HAZARD;
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_counter
        assign inc_vec[i]     = issue_accept && (ISSUE_DEST == REG_IDX_W'(i));
        assign dec_vec[i]     = WB_EN && (DEST_WB == REG_IDX_W'(i));
        assign pending_nxt[i] = (counts_nxt[i] != CNT_ZERO);

        sb_counter #(
            .CNTW       (CNTW)
        ) u_sb_counter (
            .clk        (clk),
            .rst        (rst),
            .inc        (inc_vec[i]),
            .dec        (dec_vec[i]),
            .count      (counts[i]),
            .count_next (counts_nxt[i]),
            .underflow  (underflow_vec[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PENDING <= '0;
            ERR     <= 1'b0;
        end else begin
            PENDING <= pending_nxt;
            ERR     <= ERR || (|underflow_vec);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_scoreboard
//  Description : Self-checking bench for reg_scoreboard: directed vector
//                table, randomized run against a count-array model, and an
//                asynchronous mid-cycle reset sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv, u1, u2, iwb, fl, wb;
    logic [3:0]  s1, s2, id, dwb;
    logic        hazard;
    logic [15:0] pending;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .ISSUE_VALID (iv),
        .SRC1        (s1),
        .SRC2        (s2),
        .USE_SRC1    (u1),
        .USE_SRC2    (u2),
        .ISSUE_WB_EN (iwb),
        .ISSUE_DEST  (id),
        .FLUSH       (fl),
        .WB_EN       (wb),
        .DEST_WB     (dwb),
        .HAZARD      (hazard),
        .PENDING     (pending),
        .ERR         (err)
    );

    typedef struct {
        logic        iv, u1, u2, iwb, fl, wb;
        logic [3:0]  s1, s2, id, dwb;
        logic        haz;
        logic [15:0] pend;
        logic        err;
    } vec_t;

    // Reference model: number of outstanding writes per register.
    int m_cnt [16];
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic viv, input logic [3:0] vs1, input logic vu1,
                                input logic [3:0] vs2, input logic vu2, input logic viwb,
                                input logic [3:0] vid, input logic vfl, input logic vwb,
                                input logic [3:0] vdwb, input logic vhaz,
                                input logic [15:0] vpend, input logic verr);
        vec_t v;
        v.iv = viv; v.s1 = vs1; v.u1 = vu1; v.s2 = vs2; v.u2 = vu2; v.iwb = viwb;
        v.id = vid; v.fl = vfl; v.wb = vwb; v.dwb = vdwb;
        v.haz = vhaz; v.pend = vpend; v.err = verr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        iv = v.iv; s1 = v.s1; u1 = v.u1; s2 = v.s2; u2 = v.u2; iwb = v.iwb;
        id = v.id; fl = v.fl; wb = v.wb; dwb = v.dwb;
    endtask

    task automatic idle();
        iv = 0; u1 = 0; u2 = 0; iwb = 0; fl = 0; wb = 0;
        s1 = 0; s2 = 0; id = 0; dwb = 0;
    endtask

    // Synchronous-looking reset pulse used between phases; model cleared.
    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        m_err = 0;
    endtask

    function automatic bit m_ready(input int s);
        return (m_cnt[s] == 0) || (m_cnt[s] == 1 && wb && int'(dwb) == s);
    endfunction

    function automatic bit m_hazard();
        bit h;
        h = (u1 && !m_ready(int'(s1))) || (u2 && !m_ready(int'(s2))) ||
            (iwb && m_cnt[id] == 3 && !(wb && dwb == id));
        return iv && !fl && h;
    endfunction

    function automatic logic [15:0] m_pending();
        logic [15:0] p;
        for (int i = 0; i < 16; i++) p[i] = (m_cnt[i] != 0);
        return p;
    endfunction

    vec_t tbl [13];

    initial begin
        // iv  s1 u1  s2 u2 iwb id fl wb dwb  haz pend     err
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 16'h0008, 0); // issue R3
        tbl[1]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 0); // RAW on R3
        tbl[2]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 3, 0, 16'h0000, 0); // retire bypass
        tbl[3]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 16'h0020, 0); // R5 #1
        tbl[4]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 16'h0020, 0); // R5 #2
        tbl[5]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 16'h0020, 0); // R5 #3
        tbl[6]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 16'h0020, 0); // R5 full
        tbl[7]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 1, 5, 0, 16'h0020, 0); // full + retire
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 16'h0020, 0); // R5 -> 2
        tbl[9]  = mk(1, 5, 1, 0, 0, 1, 2, 1, 0, 0, 0, 16'h0020, 0); // flushed
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 16'h0020, 1); // underflow R7
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0020, 1); // sticky
        tbl[12] = mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 16'h0020, 1); // RAW via SRC2

        // Reset state, with busy-looking stimulus applied during reset.
        rst = 1'b1;
        drive(mk(1, 3, 1, 3, 1, 1, 3, 0, 1, 3, 0, 0, 0));
        #2;
        chk("reset_hazard", 32'(hazard), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i]);
            #2;
            chk($sformatf("tbl%0d_hazard", i), 32'(hazard), 32'(tbl[i].haz));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
        end

        // Randomized run against the count model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bit exp_h;
            bit accept;
            iv  = ($urandom % 4) != 0;
            u1  = 1'($urandom);
            u2  = 1'($urandom);
            iwb = ($urandom % 4) != 0;
            fl  = ($urandom % 8) == 0;
            wb  = 1'($urandom);
            s1  = 4'($urandom_range(0, 4));
            s2  = 4'($urandom_range(0, 4));
            id  = 4'($urandom_range(0, 4));
            dwb = 4'($urandom_range(0, 4));
            if (n % 50 == 0) begin
                s1 = 4'd15; id = 4'd15;
            end
            #2;
            exp_h = m_hazard();
            chk($sformatf("rnd%0d_hazard", n), 32'(hazard), 32'(exp_h));
            accept = iv && iwb && !fl && !exp_h;
            if (wb && m_cnt[dwb] == 0) m_err = 1;
            if (!(accept && wb && id == dwb)) begin
                if (wb && m_cnt[dwb] != 0) m_cnt[dwb]--;
                if (accept) m_cnt[id]++;
            end
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_pending", n), 32'(pending), 32'(m_pending()));
            chk($sformatf("rnd%0d_err", n), 32'(err), 32'(m_err));
        end

        // Asynchronous reset mid-cycle with R4/R5 pending and ERR set.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(1, 0, 0, 0, 0, 1, 5, 0, 1, 9, 0, 0, 0));
        @(posedge clk); #1;
        chk("pre_async_pending", 32'(pending), 32'h0030);
        chk("pre_async_err", 32'(err), 32'd1);
        drive(mk(1, 4, 1, 5, 1, 1, 4, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        chk("async_pending", 32'(pending), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        chk("async_hazard", 32'(hazard), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        // First cycle after reset: reading pre-reset targets must not stall.
        drive(mk(1, 4, 1, 5, 1, 1, 4, 0, 0, 0, 0, 0, 0));
        #2;
        chk("post_rst_hazard", 32'(hazard), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_pending", 32'(pending), 32'h0010);
        chk("post_rst_err", 32'(err), 32'd0);
        // Retire of a write issued before reset is now an underflow.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0));
        @(posedge clk); #1;
        chk("stale_wb_err", 32'(err), 32'd1);
        chk("stale_wb_pending", 32'(pending), 32'h0010);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 16, number of architectural registers tracked.
REQ-002 SHALL have parameter CNTW, default 2, width of per-register in-flight counter (max 3 pending writes).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ISSUE_VALID  input  1  decoded instruction presented by ID stage.
REQ-006 SHALL have port SRC1  input  4  first source register index.
REQ-007 SHALL have port SRC2  input  4  second source register index.
REQ-008 SHALL have port USE_SRC1  input  1  SRC1 is read by the instruction.
REQ-009 SHALL have port USE_SRC2  input  1  SRC2 is read by the instruction.
REQ-010 SHALL have port ISSUE_WB_EN  input  1  instruction writes a register.
REQ-011 SHALL have port ISSUE_DEST  input  4  destination index of the instruction.
REQ-012 SHALL have port FLUSH  input  1  ID instruction squashed this cycle (branch taken).
REQ-013 SHALL have port WB_EN  input  1  write-back retiring this cycle (same signal driving the register file).
REQ-014 SHALL have port DEST_WB  input  4  index being written back.
REQ-015 SHALL have port HAZARD  output  1  stall request to IF/ID; combinational.
REQ-016 SHALL have port PENDING  output  16  bit i set when register i has nonzero count; registered.
REQ-017 SHALL have port ERR  output  1  sticky underflow error flag; registered.

Function
REQ-018 SHALL keep one CNTW-bit counter per register, count = issued-but-not-retired writes to that register.
REQ-019 SHALL define retire-bypass: source s is ready if cnt[s]==0, or cnt[s]==1 and WB_EN and DEST_WB==s (register file writes on negedge, so value is readable same cycle).
REQ-020 SHALL assert HAZARD = ISSUE_VALID & !FLUSH & ((USE_SRC1 & !ready(SRC1)) | (USE_SRC2 & !ready(SRC2)) | (ISSUE_WB_EN & cnt[ISSUE_DEST]==3 & !(WB_EN & DEST_WB==ISSUE_DEST))).
REQ-021 SHALL accept an issue in a cycle where ISSUE_VALID & ISSUE_WB_EN & !FLUSH & !HAZARD.
REQ-022 SHALL increment cnt[ISSUE_DEST] by 1 on an accepted issue.
REQ-023 SHALL decrement cnt[DEST_WB] by 1 when WB_EN and cnt[DEST_WB]!=0.
REQ-024 SHALL leave count unchanged when accepted issue and retire target the same register in the same cycle.
REQ-025 SHALL, on WB_EN with cnt[DEST_WB]==0, leave counts unchanged and set ERR; ERR clears only on reset.
REQ-026 SHALL never wrap a counter; increment at 3 is prevented by HAZARD (REQ-020).
REQ-027 SHALL update PENDING[i] = (next cnt[i] != 0) each posedge, i.e. PENDING reflects state one cycle after the event.
REQ-028 SHALL ignore ISSUE_* entirely when FLUSH is high (no increment, HAZARD low).
REQ-029 SHALL treat register 15 identically to others (no PC special-casing in this block).

Reset
REQ-030 SHALL, while rst is high, force all counters to 0, PENDING to 16'h0000, ERR to 0, asynchronously.
REQ-031 SHALL have HAZARD low during reset and in the first cycle after it for any stimulus (all counts 0, since a DEST=3 saturation is impossible).
REQ-032 SHALL discard in-flight tracking on reset mid-operation; subsequent WB_EN for pre-reset writes sets ERR.

Structure
REQ-033 SHALL place NREGS, CNTW and the 4-bit register-index width in the shared processor package.
REQ-034 SHALL implement the per-register counter as sub-module sb_counter (inc, dec, count, underflow), instantiated NREGS times via generate.

Verification
REQ-035 SHALL cover: issue R3 write (cycle 0), next cycle USE_SRC1=1 SRC1=3 -> HAZARD=1, PENDING=16'h0008.
REQ-036 SHALL cover: cnt[R3]=1, WB_EN=1 DEST_WB=3 same cycle as SRC1=3 read -> HAZARD=0; next cycle PENDING=16'h0000.
REQ-037 SHALL cover: three accepted writes to R5, fourth ISSUE_WB_EN DEST=5 with no retire -> HAZARD=1, cnt stays 3; with WB_EN DEST_WB=5 same cycle -> accepted, cnt stays 3.
REQ-038 SHALL cover: WB_EN=1 DEST_WB=7 with cnt[R7]=0 -> ERR=1 next cycle, stays 1 until rst.
REQ-039 SHALL cover: FLUSH=1 with ISSUE_VALID=1 ISSUE_DEST=2 and SRC1 pending -> HAZARD=0, cnt[R2] unchanged.
REQ-040 SHALL cover: rst pulse asynchronous to clk while PENDING=16'h0030 -> PENDING=0, ERR=0 immediately, HAZARD=0.
